// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the iterative shift-add multiplier:
//   state_e       - controller states (IDLE, RUN, FIX, DONE)
//   BPC_LEGAL     - multiplier bits retired per RUN cycle that are supported
//   bpc_legal()   - membership test against BPC_LEGAL
//   max_latency() - worst-case accept-to-valid latency in clock edges
// ---------------------------------------------------------------------------
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_e;

   localparam int BPC_LEGAL [3] = '{1, 2, 4};

   function automatic bit bpc_legal(input int bpc);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (BPC_LEGAL[i] == bpc) ok = 1'b1;
      end
      return ok;
   endfunction

   // Full-width multiplier: one RUN cycle per BPC-bit digit, one RUN cycle to
   // see the exhausted multiplier, one FIX cycle and one output-register cycle.
   function automatic int max_latency(input int width, input int bpc);
      return 3 + width / bpc;
   endfunction

endpackage

// File: rtl/mult_iter_cond_negate.sv
// ---------------------------------------------------------------------------
// cond_negate
// Combinational two's-complement conditional negation.
//   en_i  - 1 = output the two's-complement negation of in_i
//   in_i  - W-bit operand
//   out_o - en_i ? -in_i : in_i (modulo 2^W)
// ---------------------------------------------------------------------------
module cond_negate #(
   parameter int W = 32
) (
   input  logic         en_i,
   input  logic [W-1:0] in_i,
   output logic [W-1:0] out_o
);

   assign out_o = en_i ? (~in_i + W'(1)) : in_i;

endmodule

// File: rtl/mult_iter.sv
// ---------------------------------------------------------------------------
// mult_iter
// Iterative shift-add multiplier producing the full 2*WIDTH product of two
// WIDTH-bit operands, each independently signed or unsigned. Operands are
// converted to magnitudes at accept, multiplied BPC bits per cycle with early
// exit once the remaining multiplier is zero, then the sign is reapplied.
//
// Ports:
//   clk, rst            - clock; asynchronous active-high reset
//   in_valid / in_ready - request handshake (in_ready low while busy or flush)
//   in_a, in_b          - multiplicand / multiplier
//   in_sgn_a, in_sgn_b  - 1 = corresponding operand is two's complement
//   in_tag              - tag returned with the result
//   flush               - synchronous squash of any in-flight or held result
//   out_valid/out_ready - result handshake
//   out_prod, out_tag   - product and its tag, stable while out_valid
//   busy                - controller not in IDLE
// ---------------------------------------------------------------------------
module mult_iter
   import mult_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int BPC   = 1,
   parameter int TAG_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   input  logic               in_sgn_a,
   input  logic               in_sgn_b,
   input  logic [TAG_W-1:0]   in_tag,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_prod,
   output logic [TAG_W-1:0]   out_tag,
   output logic               busy
);

   localparam int PW = 2 * WIDTH;

   state_e             state_q,   state_d;
   logic [PW-1:0]      mcand_q,   mcand_d;
   logic [WIDTH-1:0]   magb_q,    magb_d;
   logic [PW-1:0]      acc_q,     acc_d;
   logic               neg_q,     neg_d;
   logic [TAG_W-1:0]   tag_q,     tag_d;
   logic               out_valid_q, out_valid_d;
   logic [PW-1:0]      out_prod_q,  out_prod_d;
   logic [TAG_W-1:0]   out_tag_q,   out_tag_d;

   logic               neg_a, neg_b;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [PW-1:0]      acc_fixed;
   logic [PW-1:0]      partial;
   logic               accept;

   assign neg_a = in_sgn_a & in_a[WIDTH-1];
   assign neg_b = in_sgn_b & in_b[WIDTH-1];

   // |-2^(WIDTH-1)| wraps to 2^(WIDTH-1), which is still correct read unsigned.
   cond_negate #(.W(WIDTH)) u_neg_a (.en_i(neg_a), .in_i(in_a),  .out_o(mag_a));
   cond_negate #(.W(WIDTH)) u_neg_b (.en_i(neg_b), .in_i(in_b),  .out_o(mag_b));
   cond_negate #(.W(PW))    u_neg_p (.en_i(neg_q), .in_i(acc_q), .out_o(acc_fixed));

   assign in_ready = (state_q == IDLE) & ~flush;
   assign accept   = in_valid & in_ready;

   // mcand * mag_b[BPC-1:0] as a sum of shifted copies of mcand.
   always_comb begin
      partial = '0;
      for (int i = 0; i < BPC; i++) begin
         if (magb_q[i]) partial = partial + (mcand_q << i);
      end
   end

   always_comb begin
      state_d     = state_q;
      mcand_d     = mcand_q;
      magb_d      = magb_q;
      acc_d       = acc_q;
      neg_d       = neg_q;
      tag_d       = tag_q;
      out_valid_d = out_valid_q;
      out_prod_d  = out_prod_q;
      out_tag_d   = out_tag_q;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               mcand_d = {{WIDTH{1'b0}}, mag_a};
               magb_d  = mag_b;
               neg_d   = neg_a ^ neg_b;
               acc_d   = '0;
               tag_d   = in_tag;
               state_d = RUN;
            end
         end
         RUN: begin
            if (magb_q == '0) begin
               state_d = FIX;
            end else begin
               acc_d   = acc_q + partial;
               mcand_d = mcand_q << BPC;
               magb_d  = magb_q >> BPC;
            end
         end
         FIX: begin
            acc_d   = acc_fixed;
            state_d = DONE;
         end
         DONE: begin
            // First DONE cycle loads the output register; valid then holds
            // until the consumer takes it.
            if (!out_valid_q) begin
               out_valid_d = 1'b1;
               out_prod_d  = acc_q;
               out_tag_d   = tag_q;
            end else if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Squash wins over everything, including a same-cycle out_ready.
      if (flush) begin
         state_d     = IDLE;
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         mcand_q     <= '0;
         magb_q      <= '0;
         acc_q       <= '0;
         neg_q       <= 1'b0;
         tag_q       <= '0;
         out_valid_q <= 1'b0;
         out_prod_q  <= '0;
         out_tag_q   <= '0;
      end else begin
         state_q     <= state_d;
         mcand_q     <= mcand_d;
         magb_q      <= magb_d;
         acc_q       <= acc_d;
         neg_q       <= neg_d;
         tag_q       <= tag_d;
         out_valid_q <= out_valid_d;
         out_prod_q  <= out_prod_d;
         out_tag_q   <= out_tag_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_prod  = out_prod_q;
   assign out_tag   = out_tag_q;
   assign busy      = (state_q != IDLE);

endmodule
